// File: rtl/elevator_call_scheduler_if.sv
// Signal bundle between an elevator cabin and its call scheduler.
// The scheduler side uses the slave modport; the cabin/hall side uses master.
interface elevator_call_scheduler_if #(
    parameter int FLOOR_COUNT = 10,
    parameter int FLOOR_W     = 4
);
    logic [FLOOR_W-1:0]     floor;
    logic                   at_floor;
    logic [FLOOR_COUNT-1:0] hall_up_req;
    logic [FLOOR_COUNT-1:0] hall_down_req;
    logic [FLOOR_COUNT-1:0] cabin_req;
    logic                   door_hold;
    logic                   motor_up;
    logic                   motor_down;
    logic                   door_open;
    logic                   direction;
    logic [FLOOR_COUNT-1:0] up_pending;
    logic [FLOOR_COUNT-1:0] down_pending;
    logic [FLOOR_COUNT-1:0] cabin_pending;
    logic                   fault;

    modport master (
        output floor, at_floor, hall_up_req, hall_down_req, cabin_req, door_hold,
        input  motor_up, motor_down, door_open, direction,
               up_pending, down_pending, cabin_pending, fault
    );

    modport slave (
        input  floor, at_floor, hall_up_req, hall_down_req, cabin_req, door_hold,
        output motor_up, motor_down, door_open, direction,
               up_pending, down_pending, cabin_pending, fault
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Collective-control scheduler for a single elevator cabin: latches hall and
// cabin calls, picks the travel direction and issues registered motor/door
// commands based on the floor position sensor.
module elevator_call_scheduler #(
    parameter int FLOOR_COUNT = 10,
    parameter int FLOOR_W     = 4,
    parameter int DOOR_CYCLES = 8
) (
    input logic                      clock,
    input logic                      reset,
    elevator_call_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    localparam logic [7:0]             DOOR_RELOAD = 8'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_COUNT-1:0] UP_MASK     = {1'b0, {(FLOOR_COUNT-1){1'b1}}};
    localparam logic [FLOOR_COUNT-1:0] DOWN_MASK   = {{(FLOOR_COUNT-1){1'b1}}, 1'b0};

    state_t                 state, state_next;
    logic [7:0]             timer, timer_next;
    logic                   direction_next, fault_next;
    logic                   at_floor_q, arrive, floor_ok;
    logic [FLOOR_COUNT-1:0] floor_oh, any_vec, up_req, down_req;
    logic [FLOOR_COUNT-1:0] clr_up, clr_down, clr_cabin;
    logic [FLOOR_COUNT-1:0] blk_up, blk_down, blk_cabin;
    logic                   above, below, here_up, here_down, here_cabin, here_any;
    logic                   at_top, at_bottom, door_req;

    // Floor decode and call summaries relative to the reported floor
    always_comb begin
        floor_ok = 32'(bus.floor) < 32'(FLOOR_COUNT);
        any_vec  = bus.up_pending | bus.down_pending | bus.cabin_pending;
        floor_oh = '0;
        above    = 1'b0;
        below    = 1'b0;
        for (int unsigned i = 0; i < 32'(FLOOR_COUNT); i++) begin
            floor_oh[i] = (32'(bus.floor) == i);
            if (i > 32'(bus.floor)) above = above | any_vec[i];
            if (i < 32'(bus.floor)) below = below | any_vec[i];
        end
        here_up    = |(bus.up_pending & floor_oh);
        here_down  = |(bus.down_pending & floor_oh);
        here_cabin = |(bus.cabin_pending & floor_oh);
        here_any   = here_up | here_down | here_cabin;
        at_top     = 32'(bus.floor) == 32'(FLOOR_COUNT - 1);
        at_bottom  = bus.floor == FLOOR_W'(0);
        arrive     = bus.at_floor & ~at_floor_q;
        up_req     = bus.hall_up_req & UP_MASK;
        down_req   = bus.hall_down_req & DOWN_MASK;
        // A call at the open-door floor in the served direction is absorbed
        door_req   = (|(bus.cabin_req & floor_oh)) |
                     (bus.direction ? |(up_req & floor_oh) : |(down_req & floor_oh));
    end

    // Next-state, service clears and door timer
    always_comb begin
        state_next     = state;
        timer_next     = timer;
        direction_next = bus.direction;
        fault_next     = bus.fault | ~floor_ok;
        clr_up         = '0;
        clr_down       = '0;
        clr_cabin      = '0;
        blk_up         = '0;
        blk_down       = '0;
        blk_cabin      = '0;
        if (fault_next) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (here_any && bus.at_floor) begin
                        state_next = DOOR;
                        timer_next = DOOR_RELOAD;
                        clr_up     = floor_oh;
                        clr_down   = floor_oh;
                        clr_cabin  = floor_oh;
                    end else if (above && below) begin
                        state_next = bus.direction ? MOVE_UP : MOVE_DOWN;
                    end else if (above) begin
                        direction_next = 1'b1;
                        state_next     = MOVE_UP;
                    end else if (below) begin
                        direction_next = 1'b0;
                        state_next     = MOVE_DOWN;
                    end
                end
                MOVE_UP: begin
                    if (arrive && (here_cabin || here_up || (here_down && !above) || at_top)) begin
                        state_next = DOOR;
                        timer_next = DOOR_RELOAD;
                        clr_cabin  = floor_oh;
                        clr_up     = floor_oh;
                        if (!above) clr_down = floor_oh;
                    end
                end
                MOVE_DOWN: begin
                    if (arrive && (here_cabin || here_down || (here_up && !below) || at_bottom)) begin
                        state_next = DOOR;
                        timer_next = DOOR_RELOAD;
                        clr_cabin  = floor_oh;
                        clr_down   = floor_oh;
                        if (!below) clr_up = floor_oh;
                    end
                end
                DOOR: begin
                    blk_cabin = floor_oh;
                    if (bus.direction) blk_up = floor_oh;
                    else               blk_down = floor_oh;
                    if (bus.door_hold || door_req) timer_next = DOOR_RELOAD;
                    else if (timer == '0)          state_next = IDLE;
                    else                           timer_next = timer - 8'd1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, registered commands and latched calls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            timer             <= '0;
            at_floor_q        <= 1'b0;
            bus.motor_up      <= 1'b0;
            bus.motor_down    <= 1'b0;
            bus.door_open     <= 1'b0;
            bus.direction     <= 1'b0;
            bus.fault         <= 1'b0;
            bus.up_pending    <= '0;
            bus.down_pending  <= '0;
            bus.cabin_pending <= '0;
        end else begin
            state             <= state_next;
            timer             <= timer_next;
            at_floor_q        <= bus.at_floor;
            bus.motor_up      <= (state_next == MOVE_UP);
            bus.motor_down    <= (state_next == MOVE_DOWN);
            bus.door_open     <= (state_next == DOOR);
            bus.direction     <= direction_next;
            bus.fault         <= fault_next;
            bus.up_pending    <= (bus.up_pending | (up_req & ~blk_up)) & ~clr_up;
            bus.down_pending  <= (bus.down_pending | (down_req & ~blk_down)) & ~clr_down;
            bus.cabin_pending <= (bus.cabin_pending | (bus.cabin_req & ~blk_cabin)) & ~clr_cabin;
        end
    end
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: directed scenarios plus a
// randomized phase, compared each cycle against a behavioural cabin model.
module tb_elevator_call_scheduler;
    localparam int FC = 10;
    localparam int DC = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    elevator_call_scheduler_if #(.FLOOR_COUNT(FC), .FLOOR_W(4)) bus ();

    elevator_call_scheduler #(
        .FLOOR_COUNT(FC),
        .FLOOR_W(4),
        .DOOR_CYCLES(DC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: calls as per-floor flags, motion as -1/0/+1, door with remaining time
    bit m_up[FC];
    bit m_dn[FC];
    bit m_cab[FC];
    int m_motion;
    bit m_door;
    int m_left;
    bit m_dir;
    bit m_fault;
    bit m_prev_at;

    // Simple cabin plant and door episode bookkeeping
    int plant_floor = 0;
    int plant_cnt   = 0;
    bit force_bad   = 0;
    bit prev_door   = 0;
    int cur_len     = 0;
    int stops[$];
    int lens[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic bit any_at(input int f);
        return m_up[f] | m_dn[f] | m_cab[f];
    endfunction

    function automatic bit any_beyond(input int f, input int d);
        for (int g = 0; g < FC; g++)
            if (((d > 0 && g > f) || (d < 0 && g < f)) && any_at(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pack(input bit a[FC]);
        logic [31:0] v = '0;
        for (int g = 0; g < FC; g++) v[g] = a[g];
        return v;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < FC; g++) begin
            m_up[g] = 0; m_dn[g] = 0; m_cab[g] = 0;
        end
        m_motion = 0; m_door = 0; m_left = 0; m_dir = 0; m_fault = 0; m_prev_at = 0;
    endtask

    task automatic model_step();
        int  f, d;
        bit  valid, nf, arr, rq, same, opp, ahead, endf, up_w, dn_w;
        bit  ru[FC], rd[FC], rc[FC], cu[FC], cd[FC], cc[FC];
        f     = int'(bus.floor);
        valid = f < FC;
        nf    = m_fault || !valid;
        arr   = bus.at_floor && !m_prev_at;
        for (int g = 0; g < FC; g++) begin
            ru[g] = bus.hall_up_req[g] && (g != FC - 1);
            rd[g] = bus.hall_down_req[g] && (g != 0);
            rc[g] = bus.cabin_req[g];
            cu[g] = 0; cd[g] = 0; cc[g] = 0;
        end
        if (nf) begin
            m_motion = 0;
            m_door   = 0;
        end else if (m_door) begin
            rq    = rc[f] || (m_dir ? ru[f] : rd[f]);
            rc[f] = 0;
            if (m_dir) ru[f] = 0; else rd[f] = 0;
            if (bus.door_hold || rq) m_left = DC - 1;
            else if (m_left == 0)    m_door = 0;
            else                     m_left--;
        end else if (m_motion == 0) begin
            up_w = any_beyond(f, 1);
            dn_w = any_beyond(f, -1);
            if (bus.at_floor && any_at(f)) begin
                m_door = 1; m_left = DC - 1;
                cu[f] = 1; cd[f] = 1; cc[f] = 1;
            end else if (up_w && dn_w) m_motion = m_dir ? 1 : -1;
            else if (up_w) begin m_dir = 1; m_motion = 1; end
            else if (dn_w) begin m_dir = 0; m_motion = -1; end
        end else begin
            d     = m_motion;
            same  = (d > 0) ? m_up[f] : m_dn[f];
            opp   = (d > 0) ? m_dn[f] : m_up[f];
            ahead = any_beyond(f, d);
            endf  = (d > 0) ? (f == FC - 1) : (f == 0);
            if (arr && (m_cab[f] || same || (opp && !ahead) || endf)) begin
                m_motion = 0; m_door = 1; m_left = DC - 1;
                cc[f] = 1;
                if (d > 0) cu[f] = 1; else cd[f] = 1;
                if (!ahead) begin
                    if (d > 0) cd[f] = 1; else cu[f] = 1;
                end
            end
        end
        for (int g = 0; g < FC; g++) begin
            m_up[g]  = (m_up[g]  | ru[g]) & !cu[g];
            m_dn[g]  = (m_dn[g]  | rd[g]) & !cd[g];
            m_cab[g] = (m_cab[g] | rc[g]) & !cc[g];
        end
        m_fault   = nf;
        m_prev_at = bus.at_floor;
    endtask

    task automatic check_model();
        chk("motor_up",      32'(bus.motor_up),      32'(m_motion == 1));
        chk("motor_down",    32'(bus.motor_down),    32'(m_motion == -1));
        chk("door_open",     32'(bus.door_open),     32'(m_door));
        chk("direction",     32'(bus.direction),     32'(m_dir));
        chk("fault",         32'(bus.fault),         32'(m_fault));
        chk("up_pending",    32'(bus.up_pending),    pack(m_up));
        chk("down_pending",  32'(bus.down_pending),  pack(m_dn));
        chk("cabin_pending", 32'(bus.cabin_pending), pack(m_cab));
    endtask

    // One clock: advance model, sample DUT after the edge, then update plant
    task automatic tick();
        if (reset) model_reset(); else model_step();
        @(posedge clock);
        #1;
        check_model();
        bus.hall_up_req   = '0;
        bus.hall_down_req = '0;
        bus.cabin_req     = '0;
        if (bus.door_open && !prev_door) stops.push_back(plant_floor);
        if (bus.door_open) cur_len++;
        else if (prev_door) begin lens.push_back(cur_len); cur_len = 0; end
        prev_door = bus.door_open;
        if (bus.motor_up || bus.motor_down) begin
            if (bus.at_floor) begin
                bus.at_floor = 1'b0; plant_cnt = 0;
            end else if (plant_cnt == 2) begin
                plant_floor += bus.motor_up ? 1 : -1;
                bus.at_floor = 1'b1;
            end else plant_cnt++;
        end else bus.at_floor = 1'b1;
        bus.floor = force_bad ? 4'd12 : 4'(plant_floor);
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int  n = 0;
        bit  busy;
        do begin
            tick();
            n++;
            busy = bus.motor_up || bus.motor_down || bus.door_open ||
                   ((bus.up_pending | bus.down_pending | bus.cabin_pending) != '0);
        end while (busy && n < budget);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic go_to(input int f);
        bus.cabin_req[f] = 1'b1;
        run_until_idle(300, "goto");
        chk("goto_floor", 32'(plant_floor), 32'(f));
    endtask

    initial begin
        bus.floor = 4'd0; bus.at_floor = 1'b1; bus.door_hold = 1'b0;
        bus.hall_up_req = '0; bus.hall_down_req = '0; bus.cabin_req = '0;
        model_reset();
        #1 reset = 1'b1;

        // 1: reset state, call latency and first move
        repeat (3) tick();
        chk("reset_cmds", {29'd0, bus.motor_up, bus.motor_down, bus.door_open}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        bus.cabin_req[5] = 1'b1;
        tick();
        chk("t1_cab_pend", 32'(bus.cabin_pending), 32'h020);
        chk("t1_motor_early", 32'(bus.motor_up), 32'd0);
        tick();
        chk("t1_motor_up", 32'(bus.motor_up), 32'd1);
        chk("t1_dir", 32'(bus.direction), 32'd1);
        run_until_idle(300, "t1");
        chk("t1_floor", 32'(plant_floor), 32'd5);

        // 2: intermediate hall-up stop, then cabin call
        go_to(0);
        stops.delete(); lens.delete();
        bus.hall_up_req[3] = 1'b1; bus.cabin_req[7] = 1'b1;
        run_until_idle(300, "t2");
        chk("t2_nstops", 32'(stops.size()), 32'd2);
        chk("t2_stop0", 32'(q_at(stops, 0)), 32'd3);
        chk("t2_stop1", 32'(q_at(stops, 1)), 32'd7);
        chk("t2_door_len", 32'(q_at(lens, 0)), 32'd8);

        // 3: hall-down call passed going up, served on the way back
        go_to(0);
        stops.delete();
        bus.cabin_req[8] = 1'b1; bus.hall_down_req[4] = 1'b1;
        run_until_idle(300, "t3");
        chk("t3_stop0", 32'(q_at(stops, 0)), 32'd8);
        chk("t3_stop1", 32'(q_at(stops, 1)), 32'd4);
        chk("t3_dir", 32'(bus.direction), 32'd0);

        // 4: door hold and in-door cabin call extend the door
        go_to(2);
        lens.delete();
        bus.hall_up_req[2] = 1'b1;
        tick(); tick();
        chk("t4_door_open", 32'(bus.door_open), 32'd1);
        bus.door_hold = 1'b1;
        repeat (20) tick();
        bus.door_hold = 1'b0;
        run_until_idle(100, "t4a");
        chk("t4_hold_len", 32'(q_at(lens, 0)), 32'd28);
        lens.delete();
        bus.hall_up_req[2] = 1'b1;
        tick(); tick();
        repeat (4) tick();
        bus.cabin_req[2] = 1'b1;
        tick();
        chk("t4_cab_absorbed", 32'(bus.cabin_pending), 32'd0);
        run_until_idle(100, "t4b");
        chk("t4_reload_len", 32'(q_at(lens, 0)), 32'd13);

        // 5: tie-break on last direction
        go_to(6); go_to(5);
        chk("t5_dir_pre0", 32'(bus.direction), 32'd0);
        bus.cabin_req[8] = 1'b1; bus.cabin_req[1] = 1'b1;
        tick(); tick();
        chk("t5_down_first", {30'd0, bus.motor_up, bus.motor_down}, 32'd1);
        run_until_idle(400, "t5a");
        go_to(4); go_to(5);
        chk("t5_dir_pre1", 32'(bus.direction), 32'd1);
        bus.cabin_req[8] = 1'b1; bus.cabin_req[1] = 1'b1;
        tick(); tick();
        chk("t5_up_first", {30'd0, bus.motor_up, bus.motor_down}, 32'd2);
        chk("t5_dir", 32'(bus.direction), 32'd1);
        run_until_idle(400, "t5b");

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) bus.cabin_req[$urandom_range(0, FC - 1)] = 1'b1;
            if ($urandom_range(0, 7) == 0) bus.hall_up_req[$urandom_range(0, FC - 1)] = 1'b1;
            if ($urandom_range(0, 7) == 0) bus.hall_down_req[$urandom_range(0, FC - 1)] = 1'b1;
            bus.door_hold = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.door_hold = 1'b0;
        run_until_idle(1000, "rand_drain");

        // 6: sensor fault while moving down, then reset mid-move
        go_to(8);
        bus.cabin_req[2] = 1'b1;
        tick(); tick();
        chk("t6_moving_down", 32'(bus.motor_down), 32'd1);
        tick();
        force_bad = 1'b1;
        bus.floor = 4'd12;
        tick();
        chk("t6_fault", 32'(bus.fault), 32'd1);
        chk("t6_motor_off", 32'(bus.motor_down), 32'd0);
        repeat (5) tick();
        force_bad = 1'b0;
        bus.floor = 4'(plant_floor);
        repeat (5) tick();
        chk("t6_fault_sticky", 32'(bus.fault), 32'd1);
        chk("t6_stay_idle", {30'd0, bus.motor_up, bus.motor_down}, 32'd0);
        chk("t6_call_kept", 32'(bus.cabin_pending[2]), 32'd1);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        bus.cabin_req[0] = 1'b1;
        tick(); tick();
        chk("t6_restart_down", 32'(bus.motor_down), 32'd1);
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("t6_async_cmds", {29'd0, bus.motor_up, bus.motor_down, bus.door_open}, 32'd0);
        chk("t6_async_state", {30'd0, bus.direction, bus.fault}, 32'd0);
        chk("t6_async_calls", 32'(bus.cabin_pending | bus.up_pending | bus.down_pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Collective-control scheduler for one elevator cabin in the elevator_function subsystem. It latches hall up/down calls and cabin calls and chooses the travel direction. It drives registered motor_up/motor_down/door_open commands from the cabin floor sensor. Temperature control is handled elsewhere and is out of scope.

Parameters:
FLOOR_COUNT  10  number of floors, indices 0..FLOOR_COUNT-1
FLOOR_W      4   width of floor index; must satisfy 2^FLOOR_W >= FLOOR_COUNT
DOOR_CYCLES  8   clock cycles the door stays open (1..255)

Ports:
clock            in   1            system clock, rising edge
reset            in   1            asynchronous, active-high reset
floor            in   FLOOR_W      current floor index from the position sensor
at_floor         in   1            1 when the cabin is level with `floor`
hall_up_req      in   FLOOR_COUNT  one-cycle pulses, hall up button per floor
hall_down_req    in   FLOOR_COUNT  one-cycle pulses, hall down button per floor
cabin_req        in   FLOOR_COUNT  one-cycle pulses, cabin button per floor
door_hold        in   1            level input; 1 holds the door timer at reload
motor_up         out  1            registered command to drive the cabin up
motor_down       out  1            registered command to drive the cabin down
door_open        out  1            registered door-open command
direction        out  1            0 = down, 1 = up; last chosen direction
up_pending       out  FLOOR_COUNT  latched hall up calls
down_pending     out  FLOOR_COUNT  latched hall down calls
cabin_pending    out  FLOOR_COUNT  latched cabin calls
fault            out  1            sticky; set when floor >= FLOOR_COUNT

Behaviour:
- Reset (async, active-high): state=IDLE. All pending vectors = 0. motor_up = motor_down = door_open = 0. direction = 0, fault = 0, door timer = 0, at_floor_q = 0. Reset mid-travel or mid-door drops all commands immediately.
- Request latching: pending[i] <= pending[i] | req[i], except bits cleared this cycle by service. A service clear at a floor beats a new request at that floor in the same cycle (see DOOR).
  - hall_up_req[FLOOR_COUNT-1] and hall_down_req[0] are ignored.
  - A request pulse in cycle n is visible on the pending outputs at cycle n+1.
- Derived signals (combinational from pending vectors):
  - any_at(f) = up[f] | down[f] | cabin[f].
  - above(f) = any pending at floors > f.
  - below(f) = any pending at floors < f.
- arrive = at_floor & ~at_floor_q, where at_floor_q is at_floor registered.
- motor_up and motor_down are never 1 simultaneously. All outputs are registered.
- IDLE (all commands 0). Priority order:
  1. any_at(floor) & at_floor -> DOOR. Clear up/down/cabin[floor].
  2. above & below -> keep direction. Go to MOVE_UP if direction=1, else MOVE_DOWN.
  3. above only -> direction=1, MOVE_UP.
  4. below only -> direction=0, MOVE_DOWN.
  5. Otherwise stay in IDLE.
  - Motor asserts the cycle after the decision: a call latched at n+1 gives motor at n+2.
- MOVE_UP (motor_up=1). On arrive at floor f, stop if any of:
  - cabin[f]
  - up[f]
  - down[f] & ~above(f)
  - f == FLOOR_COUNT-1
  - On stop: motor_up=0 next cycle and go to DOOR. Clear cabin[f] and up[f]. Clear down[f] only if ~above(f).
- MOVE_DOWN is the mirror of MOVE_UP:
  - Stop condition uses down[f], and up[f] & ~below(f).
  - Floor 0 forces a stop.
- DOOR (door_open=1):
  - Timer loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - door_hold=1 reloads the timer.
  - A new cabin_req[floor], or a hall request at floor in the served direction, reloads the timer and is not latched.
  - Timer == 0 and door_hold=0 -> IDLE. door_open=0 next cycle. The IDLE tie-break on `direction` gives continue-before-reverse.
- Fault: floor >= FLOOR_COUNT in any state sets fault. Motors are forced to 0 and the FSM goes to IDLE. While fault=1 the FSM stays in IDLE; only reset clears it. Requests keep latching.
- Arrival at an unexpected floor (e.g. a skipped sensor) is treated as a normal arrival at the reported floor.

Test Plan:
1. Reset with floor=0, at_floor=1 -> all outputs 0. Pulse cabin_req[5] at cycle n -> cabin_pending[5]=1 at n+1, motor_up=1 at n+2, direction=1.
2. Cabin moving up from floor 0 with up_pending[3] and cabin_pending[7] -> stops at floor 3 (door_open for 8 cycles, up_pending[3] cleared), resumes up, stops at 7, then returns to IDLE.
3. Moving up to cabin_pending[8] with down_pending[4] and at_floor pulses at floor 4 -> no stop at 4. After serving 8, reverses (direction=0) and stops at 4 with down_pending[4] cleared.
4. Door open at floor 2, door_hold=1 for 20 cycles -> door_open stays 1 for 20+8 cycles. cabin_req[2] during DOOR reloads the timer and cabin_pending[2] stays 0.
5. Idle at floor 5 with pending calls at floors 8 and 1, last direction=0 -> MOVE_DOWN chosen first. Repeat with direction=1 -> MOVE_UP chosen first.
6. During MOVE_DOWN drive floor=12 -> fault=1 and motor_down=0 next cycle; the FSM stays in IDLE despite pending calls. Asserting reset mid-move -> all outputs 0 immediately.
